// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: data width, bubble encoding, reset vector,
// IF/ID register layout and the per-edge fetch action.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            fault;
  } ifid_t;

  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_STALL,
    ACT_FLUSH,
    ACT_REDIRECT
  } fetch_act_e;

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds.
module ifid_reg
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc4_i,
  input  logic            fault_i,
  output logic            valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            fault_o
);

  ifid_t ifid_q, ifid_d;

  // A bubble keeps the previous pc/pc4 so the fields stay deterministic.
  always_comb begin
    ifid_d = ifid_q;
    if (bubble_i) begin
      ifid_d.valid = 1'b0;
      ifid_d.inst  = NOP_INST;
      ifid_d.fault = 1'b0;
    end else if (load_i) begin
      ifid_d.valid = 1'b1;
      ifid_d.inst  = inst_i;
      ifid_d.pc    = pc_i;
      ifid_d.pc4   = pc4_i;
      ifid_d.fault = fault_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q.valid <= 1'b0;
      ifid_q.inst  <= NOP_INST;
      ifid_q.pc    <= '0;
      ifid_q.pc4   <= '0;
      ifid_q.fault <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign valid_o = ifid_q.valid;
  assign inst_o  = ifid_q.inst;
  assign pc_o    = ifid_q.pc;
  assign pc4_o   = ifid_q.pc4;
  assign fault_o = ifid_q.fault;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, redirect/flush/stall priority,
// misaligned-target tagging and accepted-instruction counter.
module if_fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [29:0]     inst_addr,
  input  logic [XLEN-1:0] inst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_inst_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic            ifid_fault_o,
  output logic [XLEN-1:0] fetch_count_o
);

  // PC is kept as a word address; the byte-offset bits are always zero.
  logic [29:0]     pc_q, pc_d;
  logic            fault_pending_q, fault_pending_d;
  logic [XLEN-1:0] count_q, count_d;

  fetch_act_e      act;
  logic            ifid_load, ifid_bubble;
  logic [XLEN-1:0] pc_byte, pc_plus4;

  assign pc_byte   = {pc_q, 2'b00};
  assign pc_plus4  = pc_byte + 32'd4;
  assign inst_addr = pc_q;

  always_comb begin
    act = ACT_NORMAL;
    if (redirect_i)   act = ACT_REDIRECT;
    else if (flush_i) act = ACT_FLUSH;
    else if (stall_i) act = ACT_STALL;
  end

  always_comb begin
    pc_d            = pc_q;
    fault_pending_d = fault_pending_q;
    count_d         = count_q;
    ifid_load       = 1'b0;
    ifid_bubble     = 1'b0;
    unique case (act)
      ACT_REDIRECT: begin
        pc_d            = redirect_pc_i[31:2];
        fault_pending_d = |redirect_pc_i[1:0];
        ifid_bubble     = 1'b1;
      end
      ACT_FLUSH: ifid_bubble = 1'b1;
      ACT_STALL: ;
      ACT_NORMAL: begin
        pc_d            = pc_q + 30'd1;
        fault_pending_d = 1'b0;
        count_d         = count_q + 32'd1;
        ifid_load       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC[31:2];
      fault_pending_q <= 1'b0;
      count_q         <= '0;
    end else begin
      pc_q            <= pc_d;
      fault_pending_q <= fault_pending_d;
      count_q         <= count_d;
    end
  end

  ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .inst_i   (inst),
    .pc_i     (pc_byte),
    .pc4_i    (pc_plus4),
    .fault_i  (fault_pending_q),
    .valid_o  (ifid_valid_o),
    .inst_o   (ifid_inst_o),
    .pc_o     (ifid_pc_o),
    .pc4_o    (ifid_pc4_o),
    .fault_o  (ifid_fault_o)
  );

  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, mid-cycle reset, then random
// stall/flush/redirect traffic checked against a rule-level reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] inst_addr;
  logic [31:0] inst;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ifid_valid_o, ifid_fault_o;
  logic [31:0] ifid_inst_o, ifid_pc_o, ifid_pc4_o, fetch_count_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // ROM: word 2 holds addi x5,x0,0; high region unmapped (reads 0).
  function automatic logic [31:0] rom(input logic [29:0] a);
    if (a[29:24] != 6'd0) return 32'h0;
    if (a == 30'd2) return 32'h0000_0293;
    return {a[13:0], 2'b01, ~a[15:0]};
  endfunction

  assign inst = rom(inst_addr);

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_addr     (inst_addr),
    .inst          (inst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_inst_o   (ifid_inst_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_fault_o  (ifid_fault_o),
    .fetch_count_o (fetch_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state as plain variables.
  logic [31:0] m_pc, m_cnt, m_inst, m_pcf, m_pc4f;
  logic        m_pend, m_valid, m_fault;

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 1'b0; m_cnt = 32'h0;
    m_valid = 1'b0; m_inst = NOP; m_pcf = 32'h0; m_pc4f = 32'h0; m_fault = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    if (rd) begin
      m_pc = {rpc[31:2], 2'b00}; m_pend = (rpc[1:0] != 2'b00);
      m_valid = 1'b0; m_inst = NOP; m_fault = 1'b0;
    end else if (fl) begin
      m_valid = 1'b0; m_inst = NOP; m_fault = 1'b0;
    end else if (!st) begin
      m_valid = 1'b1; m_inst = rom(m_pc[31:2]); m_pcf = m_pc; m_pc4f = m_pc + 32'd4;
      m_fault = m_pend; m_pc = m_pc + 32'd4; m_pend = 1'b0; m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".addr"},  {2'b00, inst_addr}, {2'b00, m_pc[31:2]});
    check({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, m_valid});
    check({tag, ".inst"},  ifid_inst_o, m_inst);
    check({tag, ".pc"},    ifid_pc_o, m_pcf);
    check({tag, ".pc4"},   ifid_pc4_o, m_pc4f);
    check({tag, ".fault"}, {31'd0, ifid_fault_o}, {31'd0, m_fault});
    check({tag, ".count"}, fetch_count_o, m_cnt);
  endtask

  task automatic apply_reset();
    stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        st, fl, rd;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_fault;
    logic [29:0] e_ia;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vt[19];

  initial begin
    // stall flush redir target       valid pc            fault addr        count
    vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 30'h0000_0001, 32'd1};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 30'h0000_0002, 32'd2};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 30'h0000_0003, 32'd3};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 30'h0000_0004, 32'd4};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 30'h0000_0004, 32'd4};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 30'h0000_0004, 32'd4};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b0, 30'h0000_0005, 32'd5};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 32'h40,       1'b0, 32'h0000_0010, 1'b0, 30'h0000_0010, 32'd5};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0040, 1'b0, 30'h0000_0011, 32'd6};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h42,       1'b0, 32'h0000_0040, 1'b0, 30'h0000_0010, 32'd6};
    vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0040, 1'b1, 30'h0000_0011, 32'd7};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0044, 1'b0, 30'h0000_0012, 32'd8};
    vt[12] = '{1'b0, 1'b0, 1'b1, 32'h20,       1'b0, 32'h0000_0044, 1'b0, 30'h0000_0008, 32'd8};
    vt[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0044, 1'b0, 30'h0000_0008, 32'd8};
    vt[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0020, 1'b0, 30'h0000_0009, 32'd9};
    vt[15] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0020, 1'b0, 30'h0000_0009, 32'd9};
    vt[16] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0020, 1'b0, 30'h3FFF_FFFF, 32'd9};
    vt[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 30'h0000_0000, 32'd10};
    vt[18] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 30'h0000_0001, 32'd11};

    apply_reset();
    check("rst.valid", {31'd0, ifid_valid_o}, 32'd0);
    check("rst.inst",  ifid_inst_o, NOP);
    check("rst.pc",    ifid_pc_o, 32'h0);
    check("rst.pc4",   ifid_pc4_o, 32'h0);
    check("rst.fault", {31'd0, ifid_fault_o}, 32'd0);
    check("rst.count", fetch_count_o, 32'h0);
    check("rst.addr",  {2'b00, inst_addr}, 32'h0);

    for (int i = 0; i < 19; i++) begin
      stall_i = vt[i].st; flush_i = vt[i].fl;
      redirect_i = vt[i].rd; redirect_pc_i = vt[i].rpc;
      @(posedge clk); #1;
      check($sformatf("v%0d.valid", i), {31'd0, ifid_valid_o}, {31'd0, vt[i].e_valid});
      check($sformatf("v%0d.inst", i), ifid_inst_o, vt[i].e_valid ? rom(vt[i].e_pc[31:2]) : NOP);
      check($sformatf("v%0d.pc", i), ifid_pc_o, vt[i].e_pc);
      check($sformatf("v%0d.pc4", i), ifid_pc4_o, vt[i].e_pc + 32'd4);
      check($sformatf("v%0d.fault", i), {31'd0, ifid_fault_o}, {31'd0, vt[i].e_fault});
      check($sformatf("v%0d.addr", i), {2'b00, inst_addr}, {2'b00, vt[i].e_ia});
      check($sformatf("v%0d.count", i), fetch_count_o, vt[i].e_cnt);
      if (i == 2) check("v2.inst293", ifid_inst_o, 32'h0000_0293);
    end

    // Asynchronous reset mid-cycle: outputs must clear before the next edge.
    stall_i = 0; flush_i = 0; redirect_i = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_model("arst");
    @(posedge clk); #1 rst_n = 1'b1;
    compare_model("arst_hold");

    // Random traffic, targets biased near the top of memory to exercise wrap.
    for (int n = 0; n < 3000; n++) begin
      stall_i    = ($urandom_range(0, 3) == 0);
      flush_i    = ($urandom_range(0, 9) == 0);
      redirect_i = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc_i = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        1:       redirect_pc_i = $urandom;
        default: redirect_pc_i = $urandom & 32'h0000_03FF;
      endcase
      model_edge(stall_i, flush_i, redirect_i, redirect_pc_i);
      @(posedge clk); #1;
      compare_model("rnd");
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_model("rnd_arst");
        @(posedge clk); #1 rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
